voice_allocator: RTL and testbench

Parametrised polyphonic voice allocator between the MIDI decoder and the synthesis pipelines. Maps incoming note-on/note-off events onto `VOICE_COUNT` pipelines. Adds features the first-generation dispatcher lacked:
- sustain-pedal hold;
- oldest-voice stealing when all voices are busy;
- velocity-0 note-off handling;
- an all-notes-off panic;
- matching only against sounding voices.

Outputs are registered per-voice note records with one-cycle update strobes.

---
 rtl/voice_allocator.sv | 192 +++++++++++++++++++
 tb/tb_voice_allocator.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: maps note-on/off events onto VOICE_COUNT synthesis
// pipelines with sustain hold, oldest-voice stealing and an all-notes-off panic.
package voice_allocator_pkg;
    typedef enum logic {OFF = 1'b0, ON = 1'b1} note_status_t;

    typedef struct packed {
        note_status_t status;
        logic [6:0]   note_number;
        logic [6:0]   velocity;
    } note_change_t;
endpackage

module voice_allocator
    import voice_allocator_pkg::*;
#(
    parameter int VOICE_COUNT  = 4,
    parameter int STEAL_ENABLE = 1,
    parameter int AGE_WIDTH    = 8
) (
    input  logic                               clock_50_000_000,
    input  logic                               reset,
    input  note_change_t                       note,
    input  logic                               note_ready,
    input  logic                               sustain,
    input  logic                               all_notes_off,
    output note_change_t [VOICE_COUNT-1:0]     pipeline_notes,
    output logic [VOICE_COUNT-1:0]             pipeline_notes_ready,
    output logic                               note_dropped,
    output logic [$clog2(VOICE_COUNT+1)-1:0]   voices_active
);
    localparam int IDX_W = $clog2(VOICE_COUNT);
    localparam int ACT_W = $clog2(VOICE_COUNT + 1);
    localparam logic [AGE_WIDTH-1:0] AGE_MAX = '1;

    typedef enum logic [1:0] {IDLE, HELD, SUSTAINED} voice_state_t;

    voice_state_t           state_q [VOICE_COUNT];
    voice_state_t           state_d [VOICE_COUNT];
    logic [6:0]             note_q  [VOICE_COUNT];
    logic [6:0]             note_d  [VOICE_COUNT];
    logic [6:0]             vel_q   [VOICE_COUNT];
    logic [6:0]             vel_d   [VOICE_COUNT];
    logic [AGE_WIDTH-1:0]   age_q   [VOICE_COUNT];
    logic [AGE_WIDTH-1:0]   age_d   [VOICE_COUNT];
    logic [VOICE_COUNT-1:0] strobe_q, strobe_d;
    logic                   dropped_q, dropped_d;
    logic                   sustain_q, sustain_d;
    logic [ACT_W-1:0]       active_q, active_d;

    logic                   sustain_fall, is_on, is_off;
    logic                   match_found, free_found, old_found, target_ok;
    logic [IDX_W-1:0]       match_idx, free_idx, old_idx, target_idx;
    logic [AGE_WIDTH-1:0]   old_age;

    always_comb begin
        state_d      = state_q;
        note_d       = note_q;
        vel_d        = vel_q;
        age_d        = age_q;
        strobe_d     = '0;
        dropped_d    = 1'b0;
        sustain_d    = sustain;
        active_d     = '0;
        match_found  = 1'b0;
        match_idx    = '0;
        free_found   = 1'b0;
        free_idx     = '0;
        old_found    = 1'b0;
        old_idx      = '0;
        old_age      = '0;
        target_ok    = 1'b0;
        target_idx   = '0;

        sustain_fall = sustain_q && !sustain;
        is_on        = note_ready && (note.status == ON) && (note.velocity != 7'd0);
        is_off       = note_ready && !is_on;

        if (sustain_fall) begin
            for (int i = 0; i < VOICE_COUNT; i++) begin
                if (state_q[i] == SUSTAINED) begin
                    state_d[i]  = IDLE;
                    strobe_d[i] = 1'b1;
                end
            end
        end

        // Match against pre-release state so a releasing voice can still be retriggered in place.
        for (int i = 0; i < VOICE_COUNT; i++) begin
            if (!match_found && state_q[i] != IDLE && note_q[i] == note.note_number) begin
                match_found = 1'b1;
                match_idx   = IDX_W'(i);
            end
            if (!free_found && state_d[i] == IDLE) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (state_d[i] != IDLE && (!old_found || age_q[i] > old_age)) begin
                old_found = 1'b1;
                old_idx   = IDX_W'(i);
                old_age   = age_q[i];
            end
        end

        if (is_on) begin
            if (match_found) begin
                target_ok  = 1'b1;
                target_idx = match_idx;
            end else if (free_found) begin
                target_ok  = 1'b1;
                target_idx = free_idx;
            end else if (STEAL_ENABLE != 0) begin
                target_ok  = 1'b1;
                target_idx = old_idx;
            end else begin
                dropped_d = 1'b1;
            end
            if (target_ok) begin
                for (int i = 0; i < VOICE_COUNT; i++) begin
                    if (IDX_W'(i) == target_idx) begin
                        state_d[i]  = HELD;
                        note_d[i]   = note.note_number;
                        vel_d[i]    = note.velocity;
                        age_d[i]    = '0;
                        strobe_d[i] = 1'b1;
                    end else if (state_d[i] != IDLE && age_q[i] != AGE_MAX) begin
                        age_d[i] = age_q[i] + 1'b1;
                    end
                end
            end
        end else if (is_off && match_found && state_q[match_idx] == HELD) begin
            if (sustain) begin
                state_d[match_idx] = SUSTAINED;
            end else begin
                state_d[match_idx]  = IDLE;
                strobe_d[match_idx] = 1'b1;
            end
        end

        if (all_notes_off) begin
            dropped_d = 1'b0;
            for (int i = 0; i < VOICE_COUNT; i++) begin
                state_d[i]  = IDLE;
                note_d[i]   = note_q[i];
                vel_d[i]    = vel_q[i];
                age_d[i]    = '0;
                strobe_d[i] = (state_q[i] != IDLE);
            end
        end

        for (int i = 0; i < VOICE_COUNT; i++) begin
            if (state_d[i] != IDLE) begin
                active_d = active_d + ACT_W'(1);
            end
        end
    end

    always_ff @(posedge clock_50_000_000) begin
        if (reset) begin
            for (int i = 0; i < VOICE_COUNT; i++) begin
                state_q[i] <= IDLE;
                note_q[i]  <= '0;
                vel_q[i]   <= '0;
                age_q[i]   <= '0;
            end
            strobe_q  <= '0;
            dropped_q <= 1'b0;
            sustain_q <= 1'b0;
            active_q  <= '0;
        end else begin
            state_q   <= state_d;
            note_q    <= note_d;
            vel_q     <= vel_d;
            age_q     <= age_d;
            strobe_q  <= strobe_d;
            dropped_q <= dropped_d;
            sustain_q <= sustain_d;
            active_q  <= active_d;
        end
    end

    always_comb begin
        for (int i = 0; i < VOICE_COUNT; i++) begin
            pipeline_notes[i].status      = (state_q[i] == IDLE) ? OFF : ON;
            pipeline_notes[i].note_number = note_q[i];
            pipeline_notes[i].velocity    = vel_q[i];
        end
    end

    assign pipeline_notes_ready = strobe_q;
    assign note_dropped         = dropped_q;
    assign voices_active        = active_q;
endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: one stealing instance and one dropping instance share stimulus.
module tb_voice_allocator;
    import voice_allocator_pkg::*;

    logic               clock_50_000_000 = 1'b0;
    logic               reset;
    note_change_t       note;
    logic               note_ready;
    logic               sustain;
    logic               all_notes_off;

    note_change_t [3:0] notes_s, notes_d;
    logic [3:0]         ready_s, ready_d;
    logic               dropped_s, dropped_d;
    logic [2:0]         active_s, active_d;

    int errors = 0;
    int checks = 0;

    always #10 clock_50_000_000 = ~clock_50_000_000;

    voice_allocator #(.VOICE_COUNT(4), .STEAL_ENABLE(1), .AGE_WIDTH(8)) dut_steal (
        .clock_50_000_000     (clock_50_000_000),
        .reset                (reset),
        .note                 (note),
        .note_ready           (note_ready),
        .sustain              (sustain),
        .all_notes_off        (all_notes_off),
        .pipeline_notes       (notes_s),
        .pipeline_notes_ready (ready_s),
        .note_dropped         (dropped_s),
        .voices_active        (active_s)
    );

    voice_allocator #(.VOICE_COUNT(4), .STEAL_ENABLE(0), .AGE_WIDTH(8)) dut_drop (
        .clock_50_000_000     (clock_50_000_000),
        .reset                (reset),
        .note                 (note),
        .note_ready           (note_ready),
        .sustain              (sustain),
        .all_notes_off        (all_notes_off),
        .pipeline_notes       (notes_d),
        .pipeline_notes_ready (ready_d),
        .note_dropped         (dropped_d),
        .voices_active        (active_d)
    );

    function automatic logic [31:0] rec(input logic st, input logic [6:0] num, input logic [6:0] vel);
        return {17'd0, st, num, vel};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, then land 1 time unit after the capturing edge.
    task automatic applyStimulus(input logic rdy, input logic st, input logic [6:0] num,
                                 input logic [6:0] vel, input logic sus, input logic panic);
        note.status      = st ? ON : OFF;
        note.note_number = num;
        note.velocity    = vel;
        note_ready       = rdy;
        sustain          = sus;
        all_notes_off    = panic;
        @(posedge clock_50_000_000);
        #1;
        note_ready    = 1'b0;
        all_notes_off = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        note          = '0;
        note_ready    = 1'b0;
        sustain       = 1'b0;
        all_notes_off = 1'b0;
        repeat (2) @(posedge clock_50_000_000);
        #1;
        checkOutput("reset_v0", 32'(notes_s[0]), rec(0, 0, 0));
        checkOutput("reset_v3", 32'(notes_s[3]), rec(0, 0, 0));
        checkOutput("reset_strobe", 32'(ready_s), 32'h0);
        checkOutput("reset_active", 32'(active_s), 32'd0);
        checkOutput("reset_dropped", 32'(dropped_s), 32'd0);
        reset = 1'b0;

        applyStimulus(1, 1, 60, 100, 0, 0);
        checkOutput("on60_v0", 32'(notes_s[0]), rec(1, 60, 100));
        checkOutput("on60_strobe", 32'(ready_s), 32'b0001);
        checkOutput("on60_active", 32'(active_s), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("idle_strobe", 32'(ready_s), 32'b0000);
        applyStimulus(1, 0, 60, 0, 0, 0);
        checkOutput("off60_v0", 32'(notes_s[0]), rec(0, 60, 100));
        checkOutput("off60_strobe", 32'(ready_s), 32'b0001);
        checkOutput("off60_active", 32'(active_s), 32'd0);

        applyStimulus(1, 1, 60, 80, 0, 0);
        applyStimulus(1, 1, 62, 80, 0, 0);
        applyStimulus(1, 1, 64, 80, 0, 0);
        checkOutput("fill64_strobe", 32'(ready_s), 32'b0100);
        applyStimulus(1, 1, 65, 80, 0, 0);
        checkOutput("fill65_v3", 32'(notes_s[3]), rec(1, 65, 80));
        checkOutput("fill_active", 32'(active_s), 32'd4);

        applyStimulus(1, 1, 67, 90, 0, 0);
        checkOutput("steal67_strobe", 32'(ready_s), 32'b0001);
        checkOutput("steal67_v0", 32'(notes_s[0]), rec(1, 67, 90));
        checkOutput("steal67_active", 32'(active_s), 32'd4);
        checkOutput("steal67_nodrop", 32'(dropped_s), 32'd0);
        checkOutput("drop67_strobe", 32'(ready_d), 32'b0000);
        checkOutput("drop67_pulse", 32'(dropped_d), 32'd1);
        checkOutput("drop67_v0", 32'(notes_d[0]), rec(1, 60, 80));
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("drop_oneshot", 32'(dropped_d), 32'd0);

        applyStimulus(1, 1, 69, 91, 0, 0);
        checkOutput("steal69_strobe", 32'(ready_s), 32'b0010);
        checkOutput("steal69_v1", 32'(notes_s[1]), rec(1, 69, 91));
        checkOutput("drop69_pulse", 32'(dropped_d), 32'd1);

        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("panic4_strobe", 32'(ready_s), 32'b1111);
        checkOutput("panic4_active", 32'(active_s), 32'd0);
        checkOutput("panic4_drop_strobe", 32'(ready_d), 32'b1111);

        applyStimulus(1, 1, 10, 50, 0, 0);
        applyStimulus(1, 1, 11, 50, 0, 0);
        applyStimulus(1, 1, 12, 50, 0, 0);
        checkOutput("three_active", 32'(active_s), 32'd3);
        applyStimulus(1, 1, 70, 99, 0, 1);
        checkOutput("panic3_strobe", 32'(ready_s), 32'b0111);
        checkOutput("panic3_v0", 32'(notes_s[0]), rec(0, 10, 50));
        checkOutput("panic3_v3", 32'(notes_s[3]), rec(0, 65, 80));
        checkOutput("panic3_active", 32'(active_s), 32'd0);

        applyStimulus(1, 1, 60, 100, 0, 0);
        applyStimulus(1, 1, 60, 0, 0, 0);
        checkOutput("vel0_v0", 32'(notes_s[0]), rec(0, 60, 100));
        checkOutput("vel0_strobe", 32'(ready_s), 32'b0001);
        applyStimulus(1, 0, 60, 0, 0, 0);
        checkOutput("stale_strobe", 32'(ready_s), 32'b0000);

        applyStimulus(0, 0, 0, 0, 1, 0);
        applyStimulus(1, 1, 60, 100, 1, 0);
        checkOutput("sus_on_strobe", 32'(ready_s), 32'b0001);
        applyStimulus(1, 0, 60, 0, 1, 0);
        checkOutput("sus_off_strobe", 32'(ready_s), 32'b0000);
        checkOutput("sus_off_v0", 32'(notes_s[0]), rec(1, 60, 100));
        checkOutput("sus_off_active", 32'(active_s), 32'd1);
        applyStimulus(1, 1, 60, 110, 1, 0);
        checkOutput("sus_retrig_strobe", 32'(ready_s), 32'b0001);
        checkOutput("sus_retrig_v0", 32'(notes_s[0]), rec(1, 60, 110));
        applyStimulus(1, 0, 60, 0, 1, 0);
        checkOutput("sus_off2_strobe", 32'(ready_s), 32'b0000);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("sus_rel_strobe", 32'(ready_s), 32'b0001);
        checkOutput("sus_rel_v0", 32'(notes_s[0]), rec(0, 60, 110));
        checkOutput("sus_rel_active", 32'(active_s), 32'd0);

        applyStimulus(0, 0, 0, 0, 1, 0);
        applyStimulus(1, 1, 60, 100, 1, 0);
        applyStimulus(1, 1, 62, 100, 1, 0);
        applyStimulus(1, 1, 64, 100, 1, 0);
        applyStimulus(1, 0, 60, 0, 1, 0);
        applyStimulus(1, 0, 62, 0, 1, 0);
        applyStimulus(1, 0, 64, 0, 1, 0);
        checkOutput("multi_sus_active", 32'(active_s), 32'd3);
        applyStimulus(1, 1, 62, 120, 0, 0);
        checkOutput("multi_rel_strobe", 32'(ready_s), 32'b0111);
        checkOutput("multi_rel_v0", 32'(notes_s[0]), rec(0, 60, 100));
        checkOutput("multi_rel_v1", 32'(notes_s[1]), rec(1, 62, 120));
        checkOutput("multi_rel_v2", 32'(notes_s[2]), rec(0, 64, 100));
        checkOutput("multi_rel_active", 32'(active_s), 32'd1);

        reset = 1'b1;
        applyStimulus(1, 1, 70, 99, 0, 0);
        checkOutput("midreset_strobe", 32'(ready_s), 32'b0000);
        checkOutput("midreset_v1", 32'(notes_s[1]), rec(0, 0, 0));
        checkOutput("midreset_active", 32'(active_s), 32'd0);
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
